vector_instr_sender: RTL and testbench

VECTOR_INSTR_SENDER -- requirements
Module: vector_instr_sender

---
 rtl/vector_instr_sender.sv | 130 +++++++++++++
 tb/tb_vector_instr_sender.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_instr_sender.sv
// Buffers scalar-issued vector instructions with their operands in a small FIFO
// and resolves vset instructions into a new vl that is written back to the scalar side.
module vector_instr_sender #(
  parameter int DATA_FROM_SCALAR = 96,
  parameter int INSTRUCTION_BITS = 32,
  parameter int DEPTH            = 4,
  parameter int VLEN             = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTRUCTION_BITS-1:0] in_instruction,
  input  logic [31:0]                 in_rs1_data,
  input  logic [31:0]                 in_rs2_data,
  output logic                        valid_fifo,
  output logic [DATA_FROM_SCALAR-1:0] instruction_out,
  input  logic                        pop,
  output logic                        vl_valid,
  output logic [4:0]                  vl_rd,
  output logic [31:0]                 vl_value,
  output logic [2:0]                  cur_sew,
  output logic [31:0]                 cur_vl
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_FROM_SCALAR-1:0] mem [DEPTH];
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [CW-1:0]               count;

  logic                        accept;
  logic                        do_pop;
  logic [DATA_FROM_SCALAR-1:0] packet;

  logic        is_vset;
  logic [2:0]  sew;
  logic [2:0]  lmul_raw;
  logic [1:0]  lmul_eff;
  logic [4:0]  rs1_field;
  logic [4:0]  rd_field;
  logic [31:0] vlen_w;
  logic [31:0] vlmax;
  logic [31:0] avl;
  logic [31:0] new_vl;

  // A full buffer can still take a new entry when the head leaves in the same cycle.
  assign in_ready   = !rst && ((count < DEPTH_C) || ((count == DEPTH_C) && pop));
  assign accept     = in_valid && in_ready;
  assign do_pop     = !rst && pop && (count != '0);
  assign valid_fifo = (count != '0);
  assign instruction_out = mem[rd_ptr];
  assign packet     = DATA_FROM_SCALAR'({in_instruction, in_rs1_data, in_rs2_data});

  assign is_vset   = (in_instruction[6:0] == 7'b1010111) && (in_instruction[14:12] == 3'b111);
  assign sew       = in_instruction[25:23];
  assign lmul_raw  = in_instruction[22:20];
  assign rs1_field = in_instruction[19:15];
  assign rd_field  = in_instruction[11:7];
  assign lmul_eff  = lmul_raw[2] ? 2'd0 : lmul_raw[1:0];
  assign vlen_w    = 32'(VLEN);

  always_comb begin
    vlmax = '0;
    if (!sew[2]) begin
      vlmax = (vlen_w >> (3'd3 + sew)) << lmul_eff;
    end
  end

  // rs1=x0 with rd!=x0 requests the maximum; both x0 keeps the current vl.
  always_comb begin
    avl = cur_vl;
    if (rs1_field != 5'd0) begin
      avl = in_rs1_data;
    end else if (rd_field != 5'd0) begin
      avl = '1;
    end
  end

  assign new_vl = (avl < vlmax) ? avl : vlmax;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= packet;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      case ({accept, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vl_valid <= 1'b0;
      vl_rd    <= '0;
      vl_value <= '0;
      cur_sew  <= '0;
      cur_vl   <= '0;
    end else begin
      vl_valid <= accept && is_vset;
      if (accept && is_vset) begin
        vl_rd    <= rd_field;
        vl_value <= new_vl;
        cur_sew  <= sew;
        cur_vl   <= new_vl;
      end
    end
  end

endmodule

// File: tb/tb_vector_instr_sender.sv
// Self-checking bench: fixed vector table, hand sequences and random traffic
// compared against a queue-based reference model.
module tb_vector_instr_sender;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        valid_fifo;
  logic [95:0] instruction_out;
  logic        pop;
  logic        vl_valid;
  logic [4:0]  vl_rd;
  logic [31:0] vl_value;
  logic [2:0]  cur_sew;
  logic [31:0] cur_vl;

  int total = 0;
  int bad   = 0;

  vector_instr_sender #(
    .DATA_FROM_SCALAR(96), .INSTRUCTION_BITS(32), .DEPTH(DEPTH), .VLEN(256)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .valid_fifo(valid_fifo), .instruction_out(instruction_out), .pop(pop),
    .vl_valid(vl_valid), .vl_rd(vl_rd), .vl_value(vl_value),
    .cur_sew(cur_sew), .cur_vl(cur_vl)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [95:0] m_q [$];
  logic        m_vl_valid;
  logic [4:0]  m_vl_rd;
  logic [31:0] m_vl_value;
  logic [2:0]  m_cur_sew;
  logic [31:0] m_cur_vl;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_vset(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [2:0] sew, input logic [2:0] lmul);
    logic [31:0] v;
    v = '0;
    v[6:0]   = 7'b1010111;
    v[11:7]  = rd;
    v[14:12] = 3'b111;
    v[19:15] = rs1;
    v[22:20] = lmul;
    v[25:23] = sew;
    return v;
  endfunction

  function automatic logic model_ready();
    if (rst) return 1'b0;
    return (m_q.size() < DEPTH) || (m_q.size() == DEPTH && pop);
  endfunction

  // vl computed from the architectural rule using plain multiply/divide
  function automatic logic [31:0] model_vl(input logic [31:0] ins, input logic [31:0] rs1d,
                                           input logic [31:0] cvl);
    int unsigned p2 [4] = '{1, 2, 4, 8};
    int unsigned s, l;
    longint unsigned vlmax, avl;
    s = int'(ins[25:23]);
    l = int'(ins[22:20]);
    if (l > 3) l = 0;
    if (s > 3) vlmax = 0;
    else vlmax = (256 / (8 * p2[s])) * p2[l];
    if (ins[19:15] != 0) avl = rs1d;
    else if (ins[11:7] != 0) avl = 64'hFFFF_FFFF;
    else avl = cvl;
    return (avl < vlmax) ? 32'(avl) : 32'(vlmax);
  endfunction

  task automatic model_edge(input logic rdy);
    logic acc, isv;
    if (rst) begin
      m_q.delete();
      m_vl_valid = 0; m_vl_rd = 0; m_vl_value = 0; m_cur_sew = 0; m_cur_vl = 0;
      return;
    end
    acc = in_valid && rdy;
    isv = (in_instruction[6:0] == 7'b1010111) && (in_instruction[14:12] == 3'b111);
    if (pop && m_q.size() > 0) void'(m_q.pop_front());
    if (acc) m_q.push_back({in_instruction, in_rs1_data, in_rs2_data});
    m_vl_valid = acc && isv;
    if (acc && isv) begin
      m_vl_value = model_vl(in_instruction, in_rs1_data, m_cur_vl);
      m_vl_rd    = in_instruction[11:7];
      m_cur_vl   = m_vl_value;
      m_cur_sew  = in_instruction[25:23];
    end
  endtask

  // Drive one cycle, check against the model; returns the sampled in_ready.
  task automatic cycle(input logic r, input logic v, input logic [31:0] ins,
                       input logic [31:0] d1, input logic [31:0] d2, input logic p,
                       output logic rdy_seen);
    logic rdy;
    rst = r; in_valid = v; in_instruction = ins; in_rs1_data = d1; in_rs2_data = d2; pop = p;
    #1;
    rdy = model_ready();
    rdy_seen = in_ready;
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    model_edge(rdy);
    #1;
    chk("valid_fifo", valid_fifo, m_q.size() != 0);
    if (m_q.size() != 0) chk("head", instruction_out, m_q[0]);
    chk("vl_valid", vl_valid, m_vl_valid);
    chk("vl_rd", vl_rd, m_vl_rd);
    chk("vl_value", vl_value, m_vl_value);
    chk("cur_sew", cur_sew, m_cur_sew);
    chk("cur_vl", cur_vl, m_cur_vl);
  endtask

  typedef struct {
    logic        r, v, p;
    logic [31:0] ins, d1;
    logic        e_ready, e_vf, e_vlv;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_cur;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic rs;
    logic [31:0] ins_a, ins_b, ins, d1;
    logic [4:0] rdf, rsf;

    ins_a = 32'h0000_0013;
    ins_b = 32'h0000_5057;
    //            r  v  p  instr                                 rs1d   rdy vf vlv rd val cur
    tbl[0] = '{1'b0,1'b1,1'b0, ins_a,                          32'd9,  1'b1,1'b1,1'b0,5'd0,32'd0, 32'd0};
    tbl[1] = '{1'b0,1'b1,1'b0, mk_vset(5'd6,5'd5,3'd2,3'd1),    32'd100,1'b1,1'b1,1'b1,5'd6,32'd16,32'd16};
    tbl[2] = '{1'b0,1'b1,1'b0, mk_vset(5'd1,5'd0,3'd0,3'd0),    32'd0,  1'b1,1'b1,1'b1,5'd1,32'd32,32'd32};
    tbl[3] = '{1'b0,1'b1,1'b0, mk_vset(5'd0,5'd0,3'd0,3'd0),    32'd0,  1'b1,1'b1,1'b1,5'd0,32'd32,32'd32};
    tbl[4] = '{1'b0,1'b1,1'b0, ins_b,                          32'd1,  1'b0,1'b1,1'b0,5'd0,32'd32,32'd32};
    tbl[5] = '{1'b0,1'b1,1'b1, mk_vset(5'd3,5'd2,3'd5,3'd0),    32'd7,  1'b1,1'b1,1'b1,5'd3,32'd0, 32'd0};
    tbl[6] = '{1'b0,1'b0,1'b1, ins_a,                          32'd0,  1'b1,1'b1,1'b0,5'd3,32'd0, 32'd0};
    tbl[7] = '{1'b1,1'b1,1'b1, ins_a,                          32'd0,  1'b0,1'b0,1'b0,5'd0,32'd0, 32'd0};
    tbl[8] = '{1'b0,1'b0,1'b1, ins_a,                          32'd0,  1'b1,1'b0,1'b0,5'd0,32'd0, 32'd0};

    rst = 1; in_valid = 0; in_instruction = 0; in_rs1_data = 0; in_rs2_data = 0; pop = 0;
    m_q.delete();
    m_vl_valid = 0; m_vl_rd = 0; m_vl_value = 0; m_cur_sew = 0; m_cur_vl = 0;
    @(posedge clk); #1;
    cycle(1, 1, ins_a, 0, 0, 1, rs);

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].ins, tbl[i].d1, 32'hA000_0000 + 32'(i), tbl[i].p, rs);
      chk($sformatf("tbl%0d_ready", i), rs, tbl[i].e_ready);
      chk($sformatf("tbl%0d_vf", i), valid_fifo, tbl[i].e_vf);
      chk($sformatf("tbl%0d_vlv", i), vl_valid, tbl[i].e_vlv);
      chk($sformatf("tbl%0d_rd", i), vl_rd, tbl[i].e_rd);
      chk($sformatf("tbl%0d_val", i), vl_value, tbl[i].e_val);
      chk($sformatf("tbl%0d_cur", i), cur_vl, tbl[i].e_cur);
    end

    // order across pointer wrap: six pushes with a pop every other cycle, then drain
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 32'h1000_0000 + 32'(i), 32'(i * 3), 32'(i * 5), 1'(i % 2), rs);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 1, rs);
    chk("drained_vf", valid_fifo, 1'b0);

    // reset with three entries buffered and a vset pulse pending
    cycle(0, 1, ins_a, 1, 2, 0, rs);
    cycle(0, 1, ins_b, 3, 4, 0, rs);
    cycle(0, 1, mk_vset(5'd4, 5'd7, 3'd1, 3'd2), 32'd50, 5, 0, rs);
    chk("pre_rst_vlv", vl_valid, 1'b1);
    cycle(1, 0, 0, 0, 0, 0, rs);
    chk("rst_vf", valid_fifo, 1'b0);
    chk("rst_cur_vl", cur_vl, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        rdf = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        rsf = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
        ins = mk_vset(rdf, rsf, 3'($urandom), 3'($urandom));
        ins[31:26] = 6'($urandom);
      end else begin
        ins = $urandom;
      end
      d1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 80)) : $urandom;
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7, ins, d1, $urandom,
            $urandom_range(0, 1) == 1, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
